// File: rtl/riscv_v_wb_collector_pkg.sv
// Shared types for the vector writeback path: beat format, element width,
// the buffered VRF write request and the reduction byte-enable helper.
package riscv_v_wb_collector_pkg;

    localparam int RISCV_V_NUM_BYTES_DATA = 16;
    localparam int BYTE_WIDTH             = 8;
    localparam int RISCV_V_DATA_W         = RISCV_V_NUM_BYTES_DATA * BYTE_WIDTH;
    localparam int RISCV_V_VREG_ADDR_W    = 5;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } riscv_v_sew_t;

    typedef struct packed {
        logic                      valid;
        logic [RISCV_V_DATA_W-1:0] data;
    } riscv_v_wb_data_t;

    typedef struct packed {
        logic [RISCV_V_VREG_ADDR_W-1:0]    addr;
        logic [RISCV_V_DATA_W-1:0]         data;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] be;
    } riscv_v_wb_req_t;

    // A reduction result occupies only element 0, i.e. the lowest 2^sew bytes.
    function automatic logic [RISCV_V_NUM_BYTES_DATA-1:0] sew_to_be(input riscv_v_sew_t sew);
        logic [RISCV_V_NUM_BYTES_DATA-1:0] be;
        be = '0;
        for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
            be[i] = (i < (1 << int'(sew)));
        end
        return be;
    endfunction

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// Generic DEPTH-entry FIFO with push/pop/flush, occupancy count and full/empty.
// A push while full is accepted only when a pop frees a slot on the same edge.
module riscv_v_wb_fifo
    import riscv_v_wb_collector_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = riscv_v_wb_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; consumers must qualify head with !empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/riscv_v_wb_collector.sv
// Writeback collector: forms byte enables for each ALU result, buffers it and
// drains to the VRF write port; flags almost-full and sticky overflow.
module riscv_v_wb_collector
    import riscv_v_wb_collector_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RISCV_V_VREG_ADDR_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  riscv_v_wb_data_t                  result_i,
    input  logic [ADDR_W-1:0]                 result_vd_i,
    input  logic                              result_reduct_i,
    input  riscv_v_sew_t                      result_sew_i,
    input  logic [RISCV_V_NUM_BYTES_DATA-1:0] result_mask_i,
    input  logic                              flush_i,
    output logic                              vrf_wr_en_o,
    output logic [ADDR_W-1:0]                 vrf_wr_addr_o,
    output logic [RISCV_V_DATA_W-1:0]         vrf_wr_data_o,
    output logic [RISCV_V_NUM_BYTES_DATA-1:0] vrf_wr_be_o,
    input  logic                              vrf_wr_ready_i,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic                              almost_full_o,
    output logic                              overflow_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]                 addr;
        logic [RISCV_V_DATA_W-1:0]         data;
        logic [RISCV_V_NUM_BYTES_DATA-1:0] be;
    } req_t;

    req_t push_req;
    req_t head_req;
    logic full;
    logic empty;
    logic pop;

    assign push_req.addr = result_vd_i;
    assign push_req.data = result_i.data;
    assign push_req.be   = result_reduct_i ? sew_to_be(result_sew_i) : result_mask_i;

    assign pop = vrf_wr_en_o & vrf_wr_ready_i;

    riscv_v_wb_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (result_i.valid),
        .push_data (push_req),
        .pop       (pop),
        .flush     (flush_i),
        .head      (head_req),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    // Head fields are forced to zero when empty so reset/flush present a clean port.
    assign vrf_wr_en_o   = ~empty;
    assign vrf_wr_addr_o = empty ? '0 : head_req.addr;
    assign vrf_wr_data_o = empty ? '0 : head_req.data;
    assign vrf_wr_be_o   = empty ? '0 : head_req.be;

    assign almost_full_o = (count_o >= CNT_W'(DEPTH - 1));

    // When full the head is valid, so a same-cycle pop happens exactly when ready is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (result_i.valid & full & ~vrf_wr_ready_i & ~flush_i) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_v_wb_collector.sv
// Self-checking bench for riscv_v_wb_collector: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_riscv_v_wb_collector;
    import riscv_v_wb_collector_pkg::*;

    localparam int DEPTH = 4;
    localparam int NB    = RISCV_V_NUM_BYTES_DATA;
    localparam int DW    = RISCV_V_DATA_W;
    localparam int AW    = RISCV_V_VREG_ADDR_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OBS_W = 1 + AW + DW + NB + CW + 1 + 1;

    logic             clk = 1'b0;
    logic             rst;
    riscv_v_wb_data_t result;
    logic [AW-1:0]    vd;
    logic             reduct;
    riscv_v_sew_t     sew;
    logic [NB-1:0]    mask;
    logic             flush;
    logic             ready;
    logic             vrf_wr_en;
    logic [AW-1:0]    vrf_wr_addr;
    logic [DW-1:0]    vrf_wr_data;
    logic [NB-1:0]    vrf_wr_be;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             overflow;

    always #5 clk = ~clk;

    riscv_v_wb_collector #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .result_i        (result),
        .result_vd_i     (vd),
        .result_reduct_i (reduct),
        .result_sew_i    (sew),
        .result_mask_i   (mask),
        .flush_i         (flush),
        .vrf_wr_en_o     (vrf_wr_en),
        .vrf_wr_addr_o   (vrf_wr_addr),
        .vrf_wr_data_o   (vrf_wr_data),
        .vrf_wr_be_o     (vrf_wr_be),
        .vrf_wr_ready_i  (ready),
        .count_o         (count),
        .almost_full_o   (almost_full),
        .overflow_o      (overflow)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NB-1:0] be;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   n_cmp;
    int   n_err;

    logic [OBS_W-1:0] obs;
    assign obs = {vrf_wr_en, vrf_wr_addr, vrf_wr_data, vrf_wr_be, count, almost_full, overflow};

    function automatic logic [OBS_W-1:0] expected();
        ent_t h;
        h = '{default: '0};
        if (q.size() > 0) h = q[0];
        return {(q.size() > 0) ? 1'b1 : 1'b0, h.addr, h.data, h.be,
                CW'(q.size()), (q.size() >= DEPTH - 1) ? 1'b1 : 1'b0, m_ovf};
    endfunction

    function automatic logic [NB-1:0] model_be(input logic red, input int s, input logic [NB-1:0] m);
        int nbytes;
        if (!red) return m;
        nbytes = 2 ** s;
        if (nbytes >= NB) return '1;
        return NB'((32'd1 << nbytes) - 1);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle_inputs();
        result.valid = 1'b0;
        result.data  = '0;
        vd           = '0;
        reduct       = 1'b0;
        sew          = SEW_8;
        mask         = '0;
        flush        = 1'b0;
    endtask

    task automatic drive_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic red, input int s, input logic [NB-1:0] m);
        result.valid = 1'b1;
        result.data  = d;
        vd           = a;
        reduct       = red;
        sew          = riscv_v_sew_t'(s);
        mask         = m;
    endtask

    // Advance the reference model by the inputs currently applied, then clock the DUT.
    task automatic cycle();
        ent_t e;
        bit   pop;
        if (flush) begin
            q.delete();
        end else begin
            pop = (q.size() > 0) && ready;
            if (result.valid && q.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (result.valid) begin
                    e.addr = vd;
                    e.data = result.data;
                    e.be   = model_be(reduct, int'(sew), mask);
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ready = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, expected());
            end
            cycle();
        end
        n_cmp++;
        if ({vrf_wr_en, count, overflow, almost_full} !== '0) begin
            n_err++;
            $display("FAIL reset_flags: got en=%b cnt=%0d ovf=%b af=%b expected all 0",
                     vrf_wr_en, count, overflow, almost_full);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'(i);
        ready = 1'b1;
        drive_beat(5'd3, d, 1'b0, 0, 16'hFFFF);
        cycle();
        idle_inputs();
        n_cmp++;
        if ({vrf_wr_en, vrf_wr_addr, vrf_wr_be, vrf_wr_data} !== {1'b1, 5'd3, 16'hFFFF, d}) begin
            n_err++;
            $display("FAIL single_write: got en=%b addr=%0d be=%h data=%h expected en=1 addr=3 be=ffff data=%h",
                     vrf_wr_en, vrf_wr_addr, vrf_wr_be, vrf_wr_data, d);
        end
        n_cmp++;
        if (obs !== expected()) begin
            n_err++;
            $display("FAIL single_model: got %h expected %h", obs, expected());
        end
        cycle();
        n_cmp++;
        if ({vrf_wr_en, count} !== {1'b0, CW'(0)}) begin
            n_err++;
            $display("FAIL single_drained: got en=%b cnt=%0d expected en=0 cnt=0", vrf_wr_en, count);
        end
    endtask

    task automatic test_reduction();
        int            sews [3] = '{2, 3, 0};
        logic [NB-1:0] bes  [3] = '{16'h000F, 16'h00FF, 16'h0001};
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_beat(AW'($urandom), rand_data(), 1'b1, sews[k], NB'($urandom));
            cycle();
            idle_inputs();
            n_cmp++;
            if (vrf_wr_be !== bes[k]) begin
                n_err++;
                $display("FAIL reduct_be_sew%0d: got %h expected %h", sews[k], vrf_wr_be, bes[k]);
            end
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL reduct_model_sew%0d: got %h expected %h", sews[k], obs, expected());
            end
            cycle();
        end
    endtask

    task automatic test_fill_overflow();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_beat(AW'(i + 8), rand_data(), 1'b0, 0, NB'($urandom));
            cycle();
            n_cmp++;
            if ({count, almost_full} !== {CW'((i < 4) ? i + 1 : 4), (i >= 2) ? 1'b1 : 1'b0}) begin
                n_err++;
                $display("FAIL fill_count[%0d]: got cnt=%0d af=%b", i, count, almost_full);
            end
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL fill_model[%0d]: got %h expected %h", i, obs, expected());
            end
        end
        idle_inputs();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (vrf_wr_addr !== AW'(i + 8)) begin
                n_err++;
                $display("FAIL drain_order[%0d]: got addr %0d expected %0d", i, vrf_wr_addr, i + 8);
            end
            cycle();
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL drain_model[%0d]: got %h expected %h", i, obs, expected());
            end
        end
        n_cmp++;
        if ({count, overflow} !== {CW'(0), 1'b1}) begin
            n_err++;
            $display("FAIL drain_end: got cnt=%0d ovf=%b expected cnt=0 ovf=1", count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] dnew;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(AW'(i + 16), rand_data(), 1'b0, 0, NB'($urandom));
            cycle();
        end
        dnew  = rand_data();
        ready = 1'b1;
        drive_beat(5'd30, dnew, 1'b0, 0, 16'hA5A5);
        cycle();
        idle_inputs();
        n_cmp++;
        if (count !== CW'(4)) begin
            n_err++;
            $display("FAIL fullpp_count: got %0d expected 4", count);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL fullpp_model[%0d]: got %h expected %h", i, obs, expected());
            end
            cycle();
        end
        n_cmp++;
        if ({vrf_wr_en, vrf_wr_addr, vrf_wr_data, vrf_wr_be} !== {1'b1, 5'd30, dnew, 16'hA5A5}) begin
            n_err++;
            $display("FAIL fullpp_fourth: got addr=%0d be=%h data=%h expected addr=30 be=a5a5 data=%h",
                     vrf_wr_addr, vrf_wr_be, vrf_wr_data, dnew);
        end
        cycle();
    endtask

    task automatic test_flush_reset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_beat(AW'($urandom), rand_data(), 1'b0, 0, NB'($urandom));
            cycle();
        end
        flush = 1'b1;
        cycle();
        idle_inputs();
        n_cmp++;
        if ({vrf_wr_en, count} !== {1'b0, CW'(0)}) begin
            n_err++;
            $display("FAIL flush_clear: got en=%b cnt=%0d expected en=0 cnt=0", vrf_wr_en, count);
        end
        n_cmp++;
        if (obs !== expected()) begin
            n_err++;
            $display("FAIL flush_model: got %h expected %h", obs, expected());
        end
        for (int i = 0; i < 2; i++) begin
            drive_beat(AW'($urandom), rand_data(), 1'b0, 0, NB'($urandom));
            cycle();
        end
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected all zero", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (obs !== expected()) begin
            n_err++;
            $display("FAIL post_reset: got %h expected %h", obs, expected());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            if ($urandom_range(0, 2) != 0)
                drive_beat(AW'($urandom), rand_data(), 1'($urandom), int'($urandom_range(0, 3)), NB'($urandom));
            flush = ($urandom_range(0, 31) == 0);
            ready = ($urandom_range(0, 9) < 6);
            cycle();
            n_cmp++;
            if (obs !== expected()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, expected());
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ovf = 1'b0;
        test_reset();
        test_single();
        test_reduction();
        test_fill_overflow();
        test_full_push_pop();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
